// File: rtl/cache_mem_responder_if.sv
// Request/response bus between a cache controller and its backing memory responder.
// Latency: none (wires only); response timing is set by the responder.
// Backpressure: valid/ready on both the request and the response channel.
interface cache_mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/cache_mem_responder.sv
// Single-outstanding memory responder: word array, reads return data, writes echo wdata.
// Latency: response valid LATENCY cycles after request acceptance (LATENCY in 1..15).
// Backpressure: RESP holds until resp_ready; no new request is accepted until the cycle after.
module cache_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   cache_mem_responder_if.slave  bus,
   output logic                  busy
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;

   // Ready only when idle and out of reset; a request never overlaps a response.
   assign bus.req_ready  = (state == IDLE) && !rst;
   assign accept         = bus.req_valid && bus.req_ready;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign busy           = (state != IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: skip WAIT entirely for single-cycle latency builds.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)              state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt == 4'd1)         state_nxt = RESP;
         RESP: if (bus.resp_ready)      state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Latch the accepted request and run the latency countdown while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         cnt       <= 4'(LATENCY - 1);
         lat_we    <= bus.req_we;
         lat_addr  <= bus.req_addr;
         lat_wdata <= bus.req_wdata;
      end else if (state == WAIT) begin
         cnt       <= cnt - 4'd1;
      end
   end

   // Capture response data on entry to RESP; with no WAIT the live request is the source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (state == IDLE && state_nxt == RESP) begin
         rdata_q <= bus.req_we ? bus.req_wdata : mem[bus.req_addr];
      end else if (state == WAIT && state_nxt == RESP) begin
         rdata_q <= lat_we ? lat_wdata : mem[lat_addr];
      end
   end

   // Storage array: cleared by reset, written at the acceptance edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (accept && bus.req_we) begin
         mem[bus.req_addr] <= bus.req_wdata;
      end
   end
endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, sets the word-address width; the array depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, sets the data word width.
REQ-003 Parameter LATENCY, default 3, sets the cycles from request acceptance to response valid; legal range 1..15.
REQ-004 Port clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-005 Port rst  input  1  is the reset, asynchronous and active-high.
REQ-006 Port req_valid  input  1  indicates that the cache controller presents a request.
REQ-007 Port req_ready  output  1  indicates that the responder accepts a request this cycle.
REQ-008 Port req_we  input  1  selects a write (1) or a read (0).
REQ-009 Port req_addr  input  ADDR_W  is the word address.
REQ-010 Port req_wdata  input  DATA_W  is the write data.
REQ-011 Port resp_valid  output  1  indicates that a response is presented.
REQ-012 Port resp_ready  input  1  indicates that the cache controller takes the response.
REQ-013 Port resp_rdata  output  DATA_W  is the read data, or the echoed write data for writes.
REQ-014 Port busy  output  1  is high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE with rst low; it is combinational from state and rst.
REQ-017 A request SHALL be accepted on an edge where req_valid and req_ready are both 1 (cycle T); req_we, req_addr and req_wdata are latched at that edge.
REQ-018 Request inputs SHALL be ignored on every cycle in which no request is accepted.
REQ-019 A write SHALL update array[req_addr] with req_wdata at the acceptance edge.
REQ-020 On acceptance, the block SHALL move IDLE->WAIT and load the latency counter with LATENCY-1; when LATENCY==1 it moves IDLE->RESP directly.
REQ-021 In WAIT, the counter SHALL decrement once per cycle; at the edge where it reads 1, the block moves WAIT->RESP.
REQ-022 resp_valid SHALL first be high in cycle T+LATENCY, and only in RESP.
REQ-023 On entry to RESP, resp_rdata SHALL be registered as array[latched addr] for reads and as the latched wdata for writes.
REQ-024 resp_rdata SHALL hold stable while resp_valid is high.
REQ-025 RESP->IDLE SHALL occur on the edge where resp_valid and resp_ready are both 1; while resp_ready is low, RESP holds indefinitely.
REQ-026 There SHALL be no same-cycle bypass: the next request can be accepted no earlier than the cycle after the response handshake.
REQ-027 A read issued after a write to the same address SHALL return the written value; there is no hazard, because the transactions are serialized.
REQ-028 Address arithmetic SHALL be unsigned with no wrap logic; every ADDR_W-bit address is valid.
REQ-029 resp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-030 While rst is high, the block SHALL have state=IDLE, counter=0, resp_valid=0, resp_rdata=0, busy=0, req_ready=0, and every array word = 0.
REQ-031 Reset asserted mid-transaction (in WAIT or RESP) SHALL abort the transaction with no response.
REQ-032 A write accepted before the reset SHALL NOT survive it, because the array clears.
REQ-033 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Reset then read: read addr 0x05 at T -> resp_valid rises at T+3 with resp_rdata=0x00, busy=1 during T+1..T+3.
REQ-035 Write then read: write 0xA5 to 0x10, then read 0x10 -> the write response is 0xA5, and the read response at acceptance+3 is 0xA5.
REQ-036 Backpressure: hold resp_ready low for 5 cycles in RESP -> resp_valid stays 1, resp_rdata is stable, req_ready stays 0, and a single handshake returns the block to IDLE.
REQ-037 LATENCY=1 build: read accepted at T -> resp_valid at T+1, and the WAIT state is never entered.
REQ-038 Mid-operation reset: assert rst in WAIT -> resp_valid never rises, and after release a read of the previously written address returns 0x00.
REQ-039 Back-to-back: req_valid held high with resp_ready=1 -> acceptances are spaced LATENCY+1 cycles apart, and no request is dropped or duplicated.
